// File: rtl/poly2_seg_eval_if.sv
// Sample stream, result stream and coefficient-write bundle for poly2_seg_eval.
`timescale 1ns/1ps
interface poly2_seg_eval_if #(
    parameter int X_W   = 24,
    parameter int SEG_W = 7,
    parameter int A_W   = 24,
    parameter int B_W   = 20,
    parameter int C_W   = 16,
    parameter int Y_W   = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic        [X_W-1:0]   x;
    logic                    sat_en;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [Y_W-1:0]   y;
    logic                    ovf;
    logic                    cfg_we;
    logic        [SEG_W-1:0] cfg_addr;
    logic signed [A_W-1:0]   cfg_a;
    logic signed [B_W-1:0]   cfg_b;
    logic signed [C_W-1:0]   cfg_c;

    modport master (
        output in_valid, x, sat_en, out_ready, cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        input  in_ready, out_valid, y, ovf
    );

    modport slave (
        input  in_valid, x, sat_en, out_ready, cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/poly2_seg_eval.sv
// Piecewise quadratic evaluator y = a[i] + b[i]*f + c[i]*f^2 with a run-time
// loadable coefficient table, valid/ready flow control and selectable
// saturate/wrap output handling. Three pipeline stages, all stalled together.
`timescale 1ns/1ps
module poly2_seg_eval #(
    parameter int X_W       = 24,
    parameter int SEG_W     = 7,
    parameter int A_W       = 24,
    parameter int B_W       = 20,
    parameter int C_W       = 16,
    parameter int Y_W       = 24,
    parameter int OUT_SHIFT = 2 * (X_W - SEG_W)
) (
    input logic             clk,
    input logic             rst_b,
    poly2_seg_eval_if.slave bus
);
    localparam int F     = X_W - SEG_W;
    localparam int DEPTH = 1 << SEG_W;
    localparam int E_W   = A_W + B_W + C_W;
    localparam int BF_W  = B_W + F + 1;
    localparam int CF_W  = C_W + 2 * F + 1;
    localparam int TA_W  = A_W + 2 * F;
    localparam int TB_W  = BF_W + F;
    localparam int T_MAX = (TA_W > TB_W) ? ((TA_W > CF_W) ? TA_W : CF_W)
                                         : ((TB_W > CF_W) ? TB_W : CF_W);
    // Two guard bits cover the sum of three terms; keep at least Y_W+1 for the range check.
    localparam int ACC_W = (T_MAX + 2 > Y_W + 1) ? T_MAX + 2 : Y_W + 1;

    // Returns {ovf, y}: pass-through when r fits in Y_W, else clamp or keep low bits.
    function automatic logic [Y_W:0] range_fix(input logic signed [ACC_W-1:0] r,
                                               input logic sat);
        logic           fits;
        logic [Y_W-1:0] res;
        fits = (r[ACC_W-1:Y_W-1] == {(ACC_W - Y_W + 1){r[ACC_W-1]}});
        res  = r[Y_W-1:0];
        if (!fits && sat) begin
            res = r[ACC_W-1] ? {1'b1, {(Y_W - 1){1'b0}}} : {1'b0, {(Y_W - 1){1'b1}}};
        end
        return {!fits, res};
    endfunction

    logic [E_W-1:0]   tab [DEPTH];
    logic [E_W-1:0]   row;
    logic [SEG_W-1:0] seg;
    logic [F-1:0]     frac;
    logic             en;

    logic                    vld_p0;
    logic                    sat_p0;
    logic signed [A_W-1:0]   a_p0;
    logic signed [B_W-1:0]   b_p0;
    logic signed [C_W-1:0]   c_p0;
    logic        [F-1:0]     f_p0;
    logic        [2*F-1:0]   fsq_p0;

    logic signed [BF_W-1:0]  bf;
    logic signed [CF_W-1:0]  cff;

    logic                    vld_p1;
    logic                    sat_p1;
    logic signed [ACC_W-1:0] ta_p1;
    logic signed [ACC_W-1:0] tb_p1;
    logic signed [ACC_W-1:0] tc_p1;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
    logic        [Y_W:0]     fix;

    logic                    vld_p2;
    logic signed [Y_W-1:0]   y_p2;
    logic                    ovf_p2;

    // Coefficient table: one packed {a,b,c} row per segment.
    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        logic [E_W-1:0] ent;
        // Row k: cleared by reset, loaded whenever its address is written.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                ent <= '0;
            end else if (bus.cfg_we && (bus.cfg_addr == SEG_W'(k))) begin
                ent <= {bus.cfg_a, bus.cfg_b, bus.cfg_c};
            end
        end
        assign tab[k] = ent;
    end

    assign seg          = bus.x[X_W-1:F];
    assign frac         = bus.x[F-1:0];
    assign row          = tab[seg];
    assign en           = !vld_p2 || bus.out_ready;
    assign bus.in_ready = en;

    // ---- Stage 1: table lookup, f and f^2 ----
    // Capture the segment row (pre-write value on a colliding edge) and the fraction.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_p0 <= 1'b0;
            sat_p0 <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= '0;
            f_p0   <= '0;
            fsq_p0 <= '0;
        end else if (en) begin
            vld_p0 <= bus.in_valid;
            sat_p0 <= bus.sat_en;
            a_p0   <= row[E_W-1 -: A_W];
            b_p0   <= row[B_W+C_W-1 -: B_W];
            c_p0   <= row[C_W-1:0];
            f_p0   <= frac;
            fsq_p0 <= (2 * F)'(frac) * (2 * F)'(frac);
        end
    end

    // ---- Stage 2: aligned product terms ----
    // Exact signed products; f is unsigned so it gets a zero sign bit.
    always_comb begin
        bf  = BF_W'(b_p0) * BF_W'($signed({1'b0, f_p0}));
        cff = CF_W'(c_p0) * CF_W'($signed({1'b0, fsq_p0}));
    end

    // Register a<<<2F, b*f<<<F and c*f^2 at accumulator width.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_p1 <= 1'b0;
            sat_p1 <= 1'b0;
            ta_p1  <= '0;
            tb_p1  <= '0;
            tc_p1  <= '0;
        end else if (en) begin
            vld_p1 <= vld_p0;
            sat_p1 <= sat_p0;
            ta_p1  <= ACC_W'(a_p0) <<< (2 * F);
            tb_p1  <= ACC_W'(bf) <<< F;
            tc_p1  <= ACC_W'(cff);
        end
    end

    // ---- Stage 3: sum, floor shift, range handling ----
    // Full-precision sum; arithmetic shift of a signed value is a floor.
    always_comb begin
        acc     = ta_p1 + tb_p1 + tc_p1;
        shifted = acc >>> OUT_SHIFT;
        fix     = range_fix(shifted, sat_p1);
    end

    // Output register; y/ovf only change when a real sample arrives.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_p2 <= 1'b0;
            y_p2   <= '0;
            ovf_p2 <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2   <= fix[Y_W-1:0];
                ovf_p2 <= fix[Y_W];
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.y         = y_p2;
    assign bus.ovf       = ovf_p2;
endmodule

// File: tb/tb_poly2_seg_eval.sv
// Bench for poly2_seg_eval: directed cases plus a randomized run checked
// against a plain-arithmetic model of the segment table and polynomial.
`timescale 1ns/1ps
module tb_poly2_seg_eval;
    localparam int X_W   = 24;
    localparam int SEG_W = 7;
    localparam int A_W   = 24;
    localparam int B_W   = 20;
    localparam int C_W   = 16;
    localparam int Y_W   = 24;
    localparam int F     = X_W - SEG_W;
    localparam longint YMAX = 8388607;
    localparam longint YMIN = -8388608;

    typedef struct {
        logic [Y_W-1:0] y;
        logic           ovf;
    } exp_t;

    logic           clk;
    logic           rst_b;
    int             n_assert = 0;
    int             n_fail   = 0;
    exp_t           expq[$];
    logic [Y_W-1:0] got_y[$];
    logic           got_ovf[$];
    longint         tab_a[128];
    longint         tab_b[128];
    longint         tab_c[128];

    poly2_seg_eval_if #(.X_W(X_W), .SEG_W(SEG_W), .A_W(A_W), .B_W(B_W), .C_W(C_W), .Y_W(Y_W)) bus ();

    poly2_seg_eval #(.X_W(X_W), .SEG_W(SEG_W), .A_W(A_W), .B_W(B_W), .C_W(C_W), .Y_W(Y_W),
                     .OUT_SHIFT(2 * F)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] uy(input logic [Y_W-1:0] v);
        return 64'(v);
    endfunction

    function automatic logic [X_W-1:0] mkx(input int seg, input int f);
        return {SEG_W'(seg), F'(f)};
    endfunction

    // y = a + b*f/2^F + c*f^2/2^2F, floored, then saturated or wrapped to 24 bits.
    function automatic exp_t model(input logic [X_W-1:0] xv, input logic sat);
        int     seg;
        longint f, acc, r;
        exp_t   e;
        seg = int'(xv[X_W-1:F]);
        f   = longint'(xv[F-1:0]);
        acc = tab_a[seg] * (longint'(1) << (2 * F)) + tab_b[seg] * f * (longint'(1) << F)
              + tab_c[seg] * f * f;
        r   = acc >>> (2 * F);
        e.ovf = 1'b1;
        if (r > YMAX)      e.y = sat ? Y_W'(YMAX) : r[Y_W-1:0];
        else if (r < YMIN) e.y = sat ? Y_W'(YMIN) : r[Y_W-1:0];
        else begin
            e.y   = r[Y_W-1:0];
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic clear_model();
        expq.delete();
        for (int i = 0; i < 128; i++) begin
            tab_a[i] = 0;
            tab_b[i] = 0;
            tab_c[i] = 0;
        end
    endtask

    // One clock: score any output handshake, record any accepted input, then advance.
    task automatic cycle(output logic accepted);
        logic take;
        exp_t e;
        #1;
        accepted = bus.in_valid && bus.in_ready;
        take     = bus.out_valid && bus.out_ready;
        if (take) begin
            if (expq.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'(1'b0));
            end else begin
                e = expq.pop_front();
                check("sb_y", uy(bus.y), uy(e.y));
                check("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
                got_y.push_back(bus.y);
                got_ovf.push_back(bus.ovf);
            end
        end
        if (accepted) expq.push_back(model(bus.x, bus.sat_en));
        if (bus.cfg_we) begin
            tab_a[bus.cfg_addr] = longint'(bus.cfg_a);
            tab_b[bus.cfg_addr] = longint'(bus.cfg_b);
            tab_c[bus.cfg_addr] = longint'(bus.cfg_c);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic tick();
        logic dummy;
        cycle(dummy);
    endtask

    task automatic wcfg(input int seg, input longint a, input longint b, input longint c);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = SEG_W'(seg);
        bus.cfg_a    = A_W'(a);
        bus.cfg_b    = B_W'(b);
        bus.cfg_c    = C_W'(c);
        tick();
    endtask

    task automatic send(input logic [X_W-1:0] xv, input logic sat);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            bus.in_valid = 1'b1;
            bus.x        = xv;
            bus.sat_en   = sat;
            cycle(acc);
            tries++;
        end
        check("send_accepted", 64'(acc), 64'(1'b1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (expq.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        check("drain_empty", 64'(expq.size()), 64'(0));
    endtask

    initial begin
        logic           acc;
        logic [Y_W-1:0] held;
        logic [X_W-1:0] cur_x;
        int             k;
        int             t;

        rst_b         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.sat_en    = 1'b1;
        bus.out_ready = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        bus.cfg_c     = '0;
        clear_model();

        // Reset state
        #1 rst_b = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst_y", uy(bus.y), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(1'b0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Constant term and latency
        wcfg(5, 1000, 0, 0);
        bus.in_valid = 1'b1;
        bus.x        = mkx(5, 12345);
        bus.sat_en   = 1'b1;
        cycle(acc);
        check("t1_accept", 64'(acc), 64'(1'b1));
        check("t1_valid_e1", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check("t1_valid_e2", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check("t1_valid_e3", 64'(bus.out_valid), 64'(1'b1));
        check("t1_y", uy(bus.y), 64'(1000));
        check("t1_ovf", 64'(bus.ovf), 64'(1'b0));
        drain();

        // Linear term, then square term
        got_y.delete();
        got_ovf.delete();
        wcfg(1, 0, 4, 0);
        send(mkx(1, 65536), 1'b1);
        drain();
        wcfg(1, 0, 0, -8);
        send(mkx(1, 65536), 1'b1);
        drain();
        check("t2_count", 64'(got_y.size()), 64'(2));
        check("t2_lin_y", uy(got_y[0]), 64'(24'd2));
        check("t2_sq_y", uy(got_y[1]), 64'(24'hFFFFFE));

        // Saturate, then wrap
        got_y.delete();
        got_ovf.delete();
        wcfg(127, 8388607, 524287, 32767);
        send(24'hFFFFFF, 1'b1);
        send(24'hFFFFFF, 1'b0);
        drain();
        check("t3_count", 64'(got_y.size()), 64'(2));
        check("t3_sat_y", uy(got_y[0]), 64'(24'h7FFFFF));
        check("t3_sat_ovf", 64'(got_ovf[0]), 64'(1'b1));
        check("t3_wrap_y", uy(got_y[1]), 64'(24'h887FF8));
        check("t3_wrap_ovf", 64'(got_ovf[1]), 64'(1'b1));

        // Back-pressure: 10 samples, out_ready low for 5 cycles mid-stream
        for (int s = 0; s < 10; s++) wcfg(20 + s, 100 + s, 0, 0);
        got_y.delete();
        got_ovf.delete();
        k     = 0;
        t     = 0;
        held  = '0;
        cur_x = mkx(20, int'($urandom_range(0, (1 << F) - 1)));
        while ((k < 10 || expq.size() != 0) && t < 60) begin
            bus.out_ready = !(t >= 5 && t < 10);
            if (k < 10) begin
                bus.in_valid = 1'b1;
                bus.x        = cur_x;
                bus.sat_en   = 1'b1;
            end
            #1;
            if (t == 5) held = bus.y;
            if (t >= 5 && t < 10) begin
                check("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
                check("bp_out_valid", 64'(bus.out_valid), 64'(1'b1));
                check("bp_y_held", uy(bus.y), uy(held));
            end
            cycle(acc);
            if (acc) begin
                k++;
                cur_x = mkx(20 + k, int'($urandom_range(0, (1 << F) - 1)));
            end
            t++;
        end
        bus.out_ready = 1'b1;
        check("bp_sent", 64'(k), 64'(10));
        check("bp_count", 64'(got_y.size()), 64'(10));
        for (int s = 0; s < 10; s++) check("bp_order", uy(got_y[s]), 64'(100 + s));

        // Write/read collision on segment 3
        wcfg(3, 10, 0, 0);
        got_y.delete();
        got_ovf.delete();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = SEG_W'(3);
        bus.cfg_a    = A_W'(20);
        bus.cfg_b    = '0;
        bus.cfg_c    = '0;
        bus.in_valid = 1'b1;
        bus.x        = mkx(3, int'($urandom_range(0, (1 << F) - 1)));
        bus.sat_en   = 1'b1;
        cycle(acc);
        check("col_accept", 64'(acc), 64'(1'b1));
        send(mkx(3, int'($urandom_range(0, (1 << F) - 1))), 1'b1);
        drain();
        check("col_count", 64'(got_y.size()), 64'(2));
        check("col_old", uy(got_y[0]), 64'(10));
        check("col_new", uy(got_y[1]), 64'(20));

        // Asynchronous reset with samples in flight
        send(mkx(20, 1), 1'b1);
        send(mkx(21, 2), 1'b1);
        send(mkx(22, 3), 1'b1);
        #2 rst_b = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("arst_y", uy(bus.y), 64'(0));
        check("arst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        clear_model();
        @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
        tick();
        check("arst_no_stale", 64'(bus.out_valid), 64'(1'b0));
        got_y.delete();
        got_ovf.delete();
        send(mkx(5, int'($urandom_range(0, (1 << F) - 1))), 1'b1);
        drain();
        check("arst_count", 64'(got_y.size()), 64'(1));
        check("arst_tab_y", uy(got_y[0]), 64'(0));
        check("arst_tab_ovf", 64'(got_ovf[0]), 64'(1'b0));

        // Randomized traffic: writes, samples, stalls on a few segments
        for (int i = 0; i < 500; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = SEG_W'($urandom_range(0, 7));
                bus.cfg_a    = ($urandom_range(0, 1) == 1) ? A_W'($urandom) : A_W'($urandom_range(0, 4000)) - A_W'(2000);
                bus.cfg_b    = B_W'($urandom);
                bus.cfg_c    = C_W'($urandom);
            end
            if ($urandom_range(0, 2) != 0) begin
                bus.in_valid = 1'b1;
                bus.x        = mkx(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << F) - 1)));
                bus.sat_en   = 1'($urandom_range(0, 1));
            end
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
